collision_detector: RTL and testbench

Per-pixel collision detector that produces the `collisions[0:1]` vector consumed by the player controller. It watches the player sprite's draw request against the obstacle-car and finish-line draw requests during each frame's raster scan. Overlaps are accumulated over the frame and the registered result is published at the next `frame_start`. It also owns the post-crash cooldown, so one crash produces exactly one collision report.

---
 rtl/collision_pkg.sv | 16 +
 rtl/overlap_counter.sv | 37 +++
 rtl/collision_detector.sv | 139 +++++++++++++
 tb/tb_collision_detector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared constants and types for the collision detector slice.
package collision_pkg;

    localparam int unsigned COLL_CAR            = 0;
    localparam int unsigned COLL_FINISH         = 1;
    localparam int unsigned COOLDOWN_FRAMES_DEF = 130;
    localparam int unsigned HIT_COUNT_W         = 8;

    typedef logic [0:1] collision_vec_t;

    typedef enum logic {
        ST_ARMED    = 1'b0,
        ST_COOLDOWN = 1'b1
    } cd_state_t;

endpackage

// File: rtl/overlap_counter.sv
// Per-frame saturating overlap counter; restarts on frame_start, which counts as the new frame's first cycle.
module overlap_counter #(
    parameter int unsigned MAX_COUNT = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic frame_start,
    input  logic inc,
    output logic reached
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (frame_start) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_q != CNT_W'(MAX_COUNT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // reached tracks cnt_q, so at a frame_start it still describes the closing frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q   <= '0;
            reached <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            reached <= (cnt_d == CNT_W'(MAX_COUNT));
        end
    end

endmodule

// File: rtl/collision_detector.sv
// Accumulates player/obstacle and player/finish overlaps per frame and publishes
// the result at the next frame_start, with a post-crash cooldown on car reports.
module collision_detector
    import collision_pkg::*;
#(
    parameter int unsigned NUM_OBST        = 8,
    parameter int unsigned MIN_OVERLAP_PIX = 4,
    parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
    parameter int unsigned OBST_ID_W       = $clog2(NUM_OBST)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame_start,
    input  logic                   pixel_valid,
    input  logic                   player_dr,
    input  logic [NUM_OBST-1:0]    obstacle_dr,
    input  logic                   finish_dr,
    output collision_vec_t         collisions,
    output logic [OBST_ID_W-1:0]   hit_obstacle_id,
    output logic [HIT_COUNT_W-1:0] hit_count,
    output logic                   armed
);

    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic car_pix_c;
    logic fin_pix_c;
    logic car_reached;
    logic fin_reached;
    logic car_hit_c;

    logic [OBST_ID_W-1:0] low_id_c;
    logic [OBST_ID_W-1:0] cand_id;
    logic                 seen_car;

    cd_state_t            state_q, state_d;
    logic [CD_W-1:0]      cooldown_q, cooldown_d;
    collision_vec_t       coll_d;
    logic [OBST_ID_W-1:0] id_d;
    logic [HIT_COUNT_W-1:0] count_d;

    assign car_pix_c = pixel_valid & player_dr & (|obstacle_dr);
    assign fin_pix_c = pixel_valid & player_dr & finish_dr;

    overlap_counter #(.MAX_COUNT(MIN_OVERLAP_PIX)) u_car_cnt (
        .clk         (clk),
        .resetN      (resetN),
        .frame_start (frame_start),
        .inc         (car_pix_c),
        .reached     (car_reached)
    );

    overlap_counter #(.MAX_COUNT(MIN_OVERLAP_PIX)) u_fin_cnt (
        .clk         (clk),
        .resetN      (resetN),
        .frame_start (frame_start),
        .inc         (fin_pix_c),
        .reached     (fin_reached)
    );

    // Lowest set obstacle index wins when several overlap on the same pixel
    always_comb begin
        low_id_c = '0;
        for (int i = NUM_OBST - 1; i >= 0; i--) begin
            if (obstacle_dr[i]) begin
                low_id_c = OBST_ID_W'(i);
            end
        end
    end

    // Candidate ID is the obstacle of the frame's first car pixel
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cand_id  <= '0;
            seen_car <= 1'b0;
        end else if (frame_start) begin
            seen_car <= car_pix_c;
            if (car_pix_c) begin
                cand_id <= low_id_c;
            end
        end else if (car_pix_c && !seen_car) begin
            seen_car <= 1'b1;
            cand_id  <= low_id_c;
        end
    end

    always_comb begin
        state_d    = state_q;
        cooldown_d = cooldown_q;
        coll_d     = collisions;
        id_d       = hit_obstacle_id;
        count_d    = hit_count;
        car_hit_c  = 1'b0;
        if (frame_start) begin
            car_hit_c           = armed & car_reached;
            coll_d[COLL_CAR]    = car_hit_c;
            coll_d[COLL_FINISH] = fin_reached & ~car_hit_c;
            case (state_q)
                ST_ARMED: begin
                    if (car_hit_c) begin
                        id_d       = cand_id;
                        count_d    = (hit_count == '1) ? hit_count : hit_count + HIT_COUNT_W'(1);
                        cooldown_d = CD_W'(COOLDOWN_FRAMES);
                        state_d    = (COOLDOWN_FRAMES == 0) ? ST_ARMED : ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    cooldown_d = cooldown_q - CD_W'(1);
                    if (cooldown_d == '0) begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d    = ST_ARMED;
                    cooldown_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= ST_ARMED;
            cooldown_q      <= '0;
            collisions      <= '0;
            hit_obstacle_id <= '0;
            hit_count       <= '0;
            armed           <= 1'b1;
        end else begin
            state_q         <= state_d;
            cooldown_q      <= cooldown_d;
            collisions      <= coll_d;
            hit_obstacle_id <= id_d;
            hit_count       <= count_d;
            armed           <= (state_d == ST_ARMED);
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: stimulus queues per-frame expectations, a monitor checks them at each frame_start.
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       resetN;
    logic       resetN2;
    logic       frame_start;
    logic       pixel_valid;
    logic       player_dr;
    logic [7:0] obstacle_dr;
    logic       finish_dr;

    logic [0:1] collisions,  collisions2;
    logic [2:0] hit_id,      hit_id2;
    logic [7:0] hit_count,   hit_count2;
    logic       armed,       armed2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         chk_main;
        logic [0:1] coll;
        logic [2:0] id;
        logic [7:0] cnt;
        logic       armed;
        bit         chk2;
        logic [0:1] coll2;
        logic [7:0] cnt2;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    collision_detector dut (
        .clk             (clk),
        .resetN          (resetN),
        .frame_start     (frame_start),
        .pixel_valid     (pixel_valid),
        .player_dr       (player_dr),
        .obstacle_dr     (obstacle_dr),
        .finish_dr       (finish_dr),
        .collisions      (collisions),
        .hit_obstacle_id (hit_id),
        .hit_count       (hit_count),
        .armed           (armed)
    );

    // Zero cooldown lets hit_count reach saturation in a short run
    collision_detector #(.COOLDOWN_FRAMES(0)) dut_sat (
        .clk             (clk),
        .resetN          (resetN2),
        .frame_start     (frame_start),
        .pixel_valid     (pixel_valid),
        .player_dr       (player_dr),
        .obstacle_dr     (obstacle_dr),
        .finish_dr       (finish_dr),
        .collisions      (collisions2),
        .hit_obstacle_id (hit_id2),
        .hit_count       (hit_count2),
        .armed           (armed2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [0:1] coll, input int id, input int cnt, input logic arm);
        exp_t e;
        e.chk_main = 1'b1;
        e.coll     = coll;
        e.id       = 3'(id);
        e.cnt      = 8'(cnt);
        e.armed    = arm;
        e.chk2     = 1'b0;
        e.coll2    = 2'b00;
        e.cnt2     = 8'd0;
        return e;
    endfunction

    function automatic exp_t mk2(input logic [0:1] coll2, input int cnt2);
        exp_t e;
        e.chk_main = 1'b0;
        e.coll     = 2'b00;
        e.id       = 3'd0;
        e.cnt      = 8'd0;
        e.armed    = 1'b0;
        e.chk2     = 1'b1;
        e.coll2    = coll2;
        e.cnt2     = 8'(cnt2);
        return e;
    endfunction

    task automatic idle();
        pixel_valid = 1'b0;
        player_dr   = 1'b0;
        obstacle_dr = 8'h00;
        finish_dr   = 1'b0;
    endtask

    task automatic drive(input int n, input logic pv, input logic pl, input logic [7:0] ob, input logic fin);
        pixel_valid = pv;
        player_dr   = pl;
        obstacle_dr = ob;
        finish_dr   = fin;
        repeat (n) @(negedge clk);
        idle();
    endtask

    // Frame boundary; ob_fs places a car pixel on the frame_start cycle itself
    task automatic close_frame(input exp_t e, input logic [7:0] ob_fs = 8'h00);
        exp_q.push_back(e);
        if (ob_fs != 8'h00) begin
            pixel_valid = 1'b1;
            player_dr   = 1'b1;
            obstacle_dr = ob_fs;
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        idle();
    endtask

    // Monitor: results become visible right after each frame_start edge
    initial begin
        forever begin
            @(posedge clk);
            if (frame_start) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.chk_main) begin
                        chk("collisions", 32'(collisions), 32'(e.coll));
                        chk("hit_obstacle_id", 32'(hit_id), 32'(e.id));
                        chk("hit_count", 32'(hit_count), 32'(e.cnt));
                        chk("armed", 32'(armed), 32'(e.armed));
                    end
                    if (e.chk2) begin
                        chk("sat_collisions", 32'(collisions2), 32'(e.coll2));
                        chk("sat_hit_count", 32'(hit_count2), 32'(e.cnt2));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN      = 1'b0;
        resetN2     = 1'b0;
        frame_start = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("reset_collisions", 32'(collisions), 32'd0);
        chk("reset_hit_id", 32'(hit_id), 32'd0);
        chk("reset_hit_count", 32'(hit_count), 32'd0);
        chk("reset_armed", 32'(armed), 32'd1);
        resetN = 1'b1;

        // Below threshold, finish alone, finish not sticky, filtered noise
        drive(3, 1'b1, 1'b1, 8'h20, 1'b0);
        close_frame(mk(2'b00, 0, 0, 1'b1));
        drive(4, 1'b1, 1'b1, 8'h00, 1'b1);
        close_frame(mk(2'b01, 0, 0, 1'b1));
        drive(2, 1'b1, 1'b0, 8'h00, 1'b0);
        close_frame(mk(2'b00, 0, 0, 1'b1));
        drive(5, 1'b1, 1'b0, 8'h20, 1'b0);
        drive(5, 1'b0, 1'b1, 8'h20, 1'b0);
        drive(5, 1'b1, 1'b1, 8'h00, 1'b0);
        drive(3, 1'b1, 1'b1, 8'h20, 1'b0);
        close_frame(mk(2'b00, 0, 0, 1'b1));

        // Crash on obstacle 5
        drive(4, 1'b1, 1'b1, 8'h20, 1'b0);
        close_frame(mk(2'b10, 5, 1, 1'b0));

        // Cooldown: 130 suppressed edges; finish still reported in frame 5
        for (int j = 1; j <= 130; j++) begin
            drive(10, 1'b1, 1'b1, 8'h20, (j == 5));
            close_frame(mk((j == 5) ? 2'b01 : 2'b00, 5, 1, (j == 130)));
        end
        // Re-armed: car beats finish, obstacles 2 and 6 tie on the first pixel
        drive(10, 1'b1, 1'b1, 8'h44, 1'b1);
        close_frame(mk(2'b10, 2, 2, 1'b0));

        // Asynchronous reset in the middle of a cooldown frame
        drive(3, 1'b1, 1'b1, 8'h20, 1'b0);
        resetN = 1'b0;
        #1;
        chk("midreset_collisions", 32'(collisions), 32'd0);
        chk("midreset_hit_id", 32'(hit_id), 32'd0);
        chk("midreset_hit_count", 32'(hit_count), 32'd0);
        chk("midreset_armed", 32'(armed), 32'd1);
        @(negedge clk);
        resetN = 1'b1;

        // frame_start-cycle pixel belongs to the new frame and fixes its cand_id
        drive(2, 1'b1, 1'b1, 8'h20, 1'b0);
        close_frame(mk(2'b00, 0, 0, 1'b1), 8'h80);
        drive(3, 1'b1, 1'b1, 8'h01, 1'b0);
        close_frame(mk(2'b10, 7, 1, 1'b0));

        // hit_count saturation on the zero-cooldown instance
        resetN2 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            drive(4, 1'b1, 1'b1, 8'h10, 1'b0);
            close_frame(mk2(2'b10, (i > 255) ? 255 : i));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
